reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Round-robin arbiter that shares one 4-bit enable-loaded register among NUM_REQ independent writers.
- Collects write requests, selects one winner, and drives the register's Data/Enable pins for exactly one cycle.
- Returns a one-cycle Grant to the winner.
- Sits between requester FSMs and the shared register; it is the only block allowed to drive that register's Enable.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 4, data width, must match the shared register width
- PTR_W, 2, round-robin pointer width, equal to clog2(NUM_REQ)

Ports:
- Clock  in  1  rising-edge clock shared with the register
- Reset_n  in  1  synchronous, active-low reset
- Req  in  NUM_REQ  per-requester write request, level, held until Grant
- ReqData  in  NUM_REQ*DATA_W  packed write data; requester i occupies bits [i*DATA_W +: DATA_W]
- Stall  in  1  when high, no new arbitration starts
- RegData  out  DATA_W  to the register's Data input
- RegEnable  out  1  to the register's Enable input
- Grant  out  NUM_REQ  one-hot acknowledge, high in the write cycle
- Busy  out  1  high while in state WRITE

Behaviour:
- All outputs are registered.
- Reset (Reset_n low at a rising edge) sets: state=IDLE, RegData=0, RegEnable=0, Grant=0, Busy=0, pointer=0.
- State IDLE:
  - Move to WRITE only if Stall=0 and any Req bit is high.
  - Winner is the first set Req bit found scanning upward from the pointer, wrapping from NUM_REQ-1 to 0.
  - On that edge, latch RegData=winner's ReqData slice, Grant=onehot(winner), RegEnable=1, Busy=1.
  - Set pointer=(winner+1) mod NUM_REQ.
- State WRITE:
  - Lasts exactly one cycle; the register captures RegData at the edge that ends WRITE.
  - Always return to IDLE on that edge, clearing RegEnable, Grant and Busy.
  - Req and Stall are ignored during WRITE.
- Latency: Req sampled high at edge N gives RegEnable/Grant high from N to N+1, and the register Q updates at edge N+1. Peak throughput is one write per 2 cycles.
- Requester rule: drop Req (or present new data) at the edge where Grant is seen high. Because IDLE re-samples one cycle later, there is no double grant.
- Data must be stable only at the sampling edge; later ReqData changes do not affect RegData.
- Requests are never lost. Losers keep Req high and are served in round-robin order.
- Fairness: with all requesters requesting continuously, each is granted once every 2*NUM_REQ cycles.
- Stall high in IDLE holds the pointer and outputs. Stall rising during WRITE does not abort the write.
- Reset during WRITE: Enable was high before the edge, so the register still captures at the reset edge. After reset, RegEnable=0 and the pointer is 0.
- A Req bit falling before its grant is simply dropped; there is no error.
- Invariants:
  - Grant is one-hot or zero.
  - RegEnable equals (Grant != 0) equals Busy.
  - RegEnable is never high two cycles in a row.

Decomposition:
- Shared package reg_arb_pkg holds:
  - state enum {IDLE, WRITE}
  - default constants NUM_REQ=4 and DATA_W=4
  - onehot helper function
- Sub-module rr_pick: purely combinational, takes (Req, pointer) and returns (valid, winner index). It is reusable by other shared-resource arbiters.
- The top level holds the FSM, the pointer, the output registers, and the data mux.

Test Plan:
- Reset, then Req=0000 for 5 cycles -> RegEnable=0, Grant=0, Busy=0 throughout; register Q unchanged.
- Req=0100 with slice2=4'hA, dropped on Grant -> Grant=0100 and RegEnable=1 for exactly 1 cycle, RegData=A; Q=A one edge later; no second grant.
- Req=1111 held, slices 1,2,3,4 -> grants in order 0001, 0010, 0100, 1000, 0001, spaced 2 cycles apart; Q sequence 1,2,3,4.
- Pointer at 3, Req=0011 -> grants 0001 then 0010 (wrap-around works, no starvation).
- Stall=1 with Req=0010 for 4 cycles, then Stall=0 -> no grant while stalled; Grant=0010 on the first cycle after release.
- Reset_n low during WRITE with data 4'h5 -> Q=5 captured at that edge; next cycle all outputs 0 and pointer=0; a subsequent Req=1000 is granted normally.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared types, default sizes and helpers for register-write arbiters.
package reg_arb_pkg;
    typedef enum logic {IDLE, WRITE} state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 4;
    localparam int MAX_REQ     = 8;
    localparam int IDX_W       = $clog2(MAX_REQ);

    function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return MAX_REQ'(1) << idx;
    endfunction
endpackage

// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: requester-side request bus and shared-register write port.
interface reg_write_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      stall;
    logic [DATA_W-1:0]         reg_data;
    logic                      reg_enable;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;

    modport master (
        output req, req_data, stall,
        input  reg_data, reg_enable, grant, busy
    );

    modport slave (
        input  req, req_data, stall,
        output reg_data, reg_enable, grant, busy
    );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick; first set request at or above the pointer, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic               o_valid,
    output logic [PTR_W-1:0]   o_idx
);
    logic [NUM_REQ-1:0] w_rot;
    logic [PTR_W-1:0]   w_off;
    logic [PTR_W:0]     w_sum;

    // rotate so the pointer position lands at bit 0
    assign w_rot   = NUM_REQ'({i_req, i_req} >> i_ptr);
    assign o_valid = |i_req;

    always_comb begin
        w_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (w_rot[i]) w_off = PTR_W'(i);
    end

    assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_idx = (w_sum >= (PTR_W+1)'(NUM_REQ)) ? PTR_W'(w_sum - (PTR_W+1)'(NUM_REQ))
                                                  : w_sum[PTR_W-1:0];
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter giving one writer at a time a single-cycle write
// into a shared enable-loaded register; all outputs registered.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    reg_write_arbiter_if.slave bus
);
    state_t              r_state;
    state_t              w_next;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    w_ptr_nxt;
    logic [PTR_W-1:0]    w_idx;
    logic                w_valid;
    logic [DATA_W-1:0]   r_reg_data;
    logic [DATA_W-1:0]   w_data_nxt;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  w_grant_nxt;

    rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // WRITE always lasts one cycle, so requests are only sampled from IDLE
    always_comb w_next = (r_state == IDLE && !bus.stall && w_valid) ? WRITE : IDLE;

    always_comb begin
        w_grant_nxt = (w_next == WRITE) ? NUM_REQ'(onehot(IDX_W'(w_idx))) : '0;
        w_data_nxt  = (w_next == WRITE) ? bus.req_data[int'(w_idx)*DATA_W +: DATA_W] : r_reg_data;
        w_ptr_nxt   = (w_next == WRITE) ? ((w_idx == PTR_W'(NUM_REQ-1)) ? '0 : w_idx + 1'b1) : r_ptr;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr      <= '0;
            r_reg_data <= '0;
            r_grant    <= '0;
        end else begin
            r_ptr      <= w_ptr_nxt;
            r_reg_data <= w_data_nxt;
            r_grant    <= w_grant_nxt;
        end
    end

    assign bus.reg_data   = r_reg_data;
    assign bus.grant      = r_grant;
    assign bus.reg_enable = (r_state == WRITE);
    assign bus.busy       = (r_state == WRITE);
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed + randomized scoreboard bench; a queue-based model predicts
// each write (cycle, grant, data) and a negedge monitor checks the DUT and a modelled register.
module tb_reg_write_arbiter;
    localparam int N = 4;
    localparam int W = 4;

    typedef struct {
        int           cyc;
        logic [N-1:0] grant;
        logic [W-1:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    reg_write_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

    reg_write_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // the shared register the arbiter feeds
    logic [W-1:0] q;
    always_ff @(posedge clk) if (bus.reg_enable) q <= bus.reg_data;

    exp_t         sb[$];
    exp_t         mon_e;
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           m_ptr    = 0;
    int           m_win    = 0;
    bit           m_wr     = 1'b0;
    bit           mon_en   = 1'b0;
    bit           hold_req = 1'b0;
    bit           prev_en  = 1'b0;
    bit           q_pend   = 1'b0;
    logic [W-1:0] exp_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // one clock edge: model decides from the inputs the DUT sampled, then inputs may change
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_wr  = 1'b0;
            m_ptr = 0;
        end else if (m_wr) begin
            m_wr = 1'b0;
        end else if (!bus.stall && bus.req != '0) begin
            for (int k = N - 1; k >= 0; k--)
                if (bus.req[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
            sb.push_back('{cyc, N'(1) << m_win, bus.req_data[m_win*W +: W]});
            m_ptr = (m_win + 1) % N;
            m_wr  = 1'b1;
        end
        #1;
        if (m_wr && !hold_req) bus.req[m_win] = 1'b0;
    endtask

    task automatic chk_idle_outputs();
        chk("rst_reg_data", 32'(bus.reg_data), 32'(0));
        chk("rst_enable", 32'(bus.reg_enable), 32'(0));
        chk("rst_grant", 32'(bus.grant), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
    endtask

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (q_pend) begin
                chk("reg_q", 32'(q), 32'(exp_q));
                q_pend = 1'b0;
            end
            chk("enable_eq_busy", 32'(bus.reg_enable), 32'(bus.busy));
            chk("enable_eq_grant", 32'(bus.reg_enable), 32'(bus.grant != '0));
            chk("grant_onehot0", 32'($onehot0(bus.grant)), 32'(1));
            chk("enable_back_to_back", 32'(prev_en && bus.reg_enable), 32'(0));
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("grant_cycle", 32'(cyc), 32'(sb[0].cyc));
                void'(sb.pop_front());
            end
            if (bus.reg_enable === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_grant", 32'(bus.grant), 32'(0));
                end else begin
                    mon_e = sb.pop_front();
                    chk("grant_cycle", 32'(cyc), 32'(mon_e.cyc));
                    chk("grant", 32'(bus.grant), 32'(mon_e.grant));
                    chk("reg_data", 32'(bus.reg_data), 32'(mon_e.data));
                    exp_q  = mon_e.data;
                    q_pend = 1'b1;
                end
            end
            prev_en = bus.reg_enable;
        end
    end

    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        bus.stall    = 1'b0;
        rst_n        = 1'b0;
        tick();
        tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        chk_idle_outputs();

        repeat (5) tick();

        bus.req_data[2*W +: W] = 4'hA;
        bus.req = 4'b0100;
        repeat (4) tick();

        rst_n = 1'b0;
        tick();
        rst_n        = 1'b1;
        hold_req     = 1'b1;
        bus.req_data = {4'h4, 4'h3, 4'h2, 4'h1};
        bus.req      = 4'b1111;
        repeat (10) tick();
        hold_req = 1'b0;
        bus.req  = '0;
        repeat (2) tick();

        bus.req = 4'b0100;
        repeat (2) tick();
        bus.req_data[0 +: W] = 4'h7;
        bus.req_data[W +: W] = 4'h8;
        bus.req = 4'b0011;
        repeat (4) tick();

        bus.stall = 1'b1;
        bus.req   = 4'b0010;
        repeat (4) tick();
        bus.stall = 1'b0;
        repeat (2) tick();

        bus.req_data[0 +: W] = 4'h5;
        bus.req = 4'b0001;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_idle_outputs();
        bus.req_data[3*W +: W] = 4'hC;
        bus.req_data[0 +: W]   = 4'h9;
        bus.req = 4'b1001;
        repeat (4) tick();

        for (int r = 0; r < 400; r++) begin
            bus.stall = ($urandom_range(0, 4) == 0);
            rst_n     = ($urandom_range(0, 59) != 0);
            for (int i = 0; i < N; i++) begin
                if (!bus.req[i]) begin
                    bus.req_data[i*W +: W] = W'($urandom);
                    bus.req[i] = ($urandom_range(0, 2) == 0);
                end else if ($urandom_range(0, 31) == 0) begin
                    bus.req[i] = 1'b0;
                end
            end
            tick();
        end

        rst_n     = 1'b1;
        bus.stall = 1'b0;
        bus.req   = '0;
        repeat (4) tick();
        @(negedge clk);
        chk("pending_writes", 32'(sb.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
